// File: rtl/vga_reg_writer.sv
// vga_reg_writer
//
// Stages register writes for the VGA peripheral and replays them as a
// back-to-back Avalon-MM write burst during vertical blanking, so that
// register updates never tear a visible frame.
//
// Handshakes:
//   push   : an entry is taken on a rising edge where push_valid && push_ready.
//            push_ready is low while the burst is running or the buffer is full.
//   Avalon : the initiator presents chipselect/write/address/writedata; the
//            head entry is consumed on each edge where write && !waitrequest,
//            and the bus holds its values while waitrequest is high.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   push_valid/addr/data  staging-buffer write, push_ready back-pressure
//   commit                request to flush at the next vblank_start
//   vblank_start          one-cycle pulse at the first blanked line
//   waitrequest           target stall
//   chipselect, write,    registered Avalon-MM write bus
//   address, writedata
//   busy                  armed or bursting
//   done                  one-cycle pulse after a flush completes
//   overflow              sticky: a push was offered while the buffer was full
module vga_reg_writer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_valid,
    input  logic [5:0]  push_addr,
    input  logic [15:0] push_data,
    output logic        push_ready,
    input  logic        commit,
    input  logic        vblank_start,
    input  logic        waitrequest,
    output logic        chipselect,
    output logic        write,
    output logic [5:0]  address,
    output logic [15:0] writedata,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t state, state_next;

    logic [21:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          push_fire;
    logic          pop;
    logic          bus_q;
    logic          bus_next;
    logic          done_next;
    logic [5:0]    addr_next;
    logic [15:0]   data_next;
    logic [21:0]   head_entry;
    logic [21:0]   second_entry;

    assign push_ready   = (state != BURST) && (count < FULL);
    assign push_fire    = push_valid && push_ready;
    assign busy         = (state != IDLE);
    assign chipselect   = bus_q;
    assign write        = bus_q;
    assign head_entry   = mem[rd_ptr];
    // Entry behind the head; pointer arithmetic wraps naturally at DEPTH.
    assign second_entry = mem[rd_ptr + PW'(1)];

    // Staging storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_next  = 1'b0;
        bus_next   = 1'b0;
        addr_next  = 6'd0;
        data_next  = 16'd0;
        case (state)
            IDLE: begin
                if (commit) begin
                    // A push in the same cycle as commit joins this flush.
                    if (count == '0 && !push_fire) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (vblank_start) begin
                    // Load the head now so write rises on the very next cycle.
                    state_next = BURST;
                    bus_next   = 1'b1;
                    addr_next  = head_entry[21:16];
                    data_next  = head_entry[15:0];
                end
            end
            BURST: begin
                if (waitrequest) begin
                    bus_next  = 1'b1;
                    addr_next = address;
                    data_next = writedata;
                end else begin
                    pop = 1'b1;
                    if (count == ONE) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bus_next  = 1'b1;
                        addr_next = second_entry[21:16];
                        data_next = second_entry[15:0];
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            bus_q     <= 1'b0;
            address   <= 6'd0;
            writedata <= 16'd0;
        end else begin
            state     <= state_next;
            done      <= done_next;
            bus_q     <= bus_next;
            address   <= addr_next;
            writedata <= data_next;
            if (push_valid && count == FULL && state != BURST) begin
                overflow <= 1'b1;
            end
            if (push_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_fire, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
